// File: rtl/curve25519_host_regs_pkg.sv
// Shared address map, register bit positions and sequencer states for the
// Curve25519 host register front end.
package curve25519_host_regs_pkg;

    localparam int FE_W = 255;

    localparam logic [7:0] N_BASE   = 8'h00;
    localparam logic [7:0] Q_BASE   = 8'h20;
    localparam logic [7:0] RES_BASE = 8'h40;
    localparam logic [7:0] CTRL     = 8'h60;
    localparam logic [7:0] STATUS   = 8'h61;
    localparam logic [7:0] CYC_BASE = 8'h64;

    localparam int CTRL_GO  = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/curve25519_clamp.sv
// Combinational scalar clamp: clears bits 0..2 and sets bit 254 when enabled;
// zero latency, no flow control.
module curve25519_clamp
    import curve25519_host_regs_pkg::*;
#(
    parameter bit CLAMP = 1'b1
) (
    input  logic [FE_W-1:0] k_i,
    output logic [FE_W-1:0] k_o
);

    always_comb begin
        k_o = k_i;
        if (CLAMP) begin
            k_o[2:0]      = 3'b000;
            k_o[FE_W-1]   = 1'b1;
        end
    end

endmodule

// File: rtl/curve25519_host_regs.sv
// Byte-wide host register file that launches the Curve25519 engine and captures its result.
// Reads return one cycle after rd_en; no backpressure, writes that collide with a busy engine are dropped and flagged.
module curve25519_host_regs
    import curve25519_host_regs_pkg::*;
#(
    parameter bit CLAMP = 1'b1,
    parameter int CNT_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [7:0]      wr_addr,
    input  logic [7:0]      wr_data,
    input  logic            rd_en,
    input  logic [7:0]      rd_addr,
    output logic [7:0]      rd_data,
    output logic            rd_valid,
    output logic            irq,
    output logic            eng_start,
    output logic [FE_W-1:0] eng_n,
    output logic [FE_W-1:0] eng_q,
    input  logic            eng_done,
    input  logic [FE_W-1:0] eng_result
);

    state_e            state_q, state_d;
    logic [255:0]      n_q, n_d;
    logic [255:0]      q_q, q_d;
    logic [FE_W-1:0]   res_q, res_d;
    logic [FE_W-1:0]   snap_n_q, snap_n_d;
    logic [FE_W-1:0]   snap_q_q, snap_q_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q;

    logic              busy;
    logic              wr_n, wr_q, wr_ctrl, go, clr;
    logic [FE_W-1:0]   n_clamped;
    logic [255:0]      res_full;
    logic [31:0]       cyc_ext;

    curve25519_clamp #(.CLAMP(CLAMP)) u_clamp (
        .k_i (n_q[FE_W-1:0]),
        .k_o (n_clamped)
    );

    assign busy    = (state_q != S_IDLE);
    assign wr_n    = wr_en && (wr_addr[7:5] == N_BASE[7:5]);
    assign wr_q    = wr_en && (wr_addr[7:5] == Q_BASE[7:5]);
    assign wr_ctrl = wr_en && (wr_addr == CTRL);
    assign go      = wr_ctrl && wr_data[CTRL_GO];
    assign clr     = wr_ctrl && wr_data[CTRL_CLR];
    assign res_full = {1'b0, res_q};
    assign cyc_ext  = 32'(cyc_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        q_d      = q_q;
        res_d    = res_q;
        snap_n_d = snap_n_q;
        snap_q_d = snap_q_q;
        done_d   = done_q;
        err_d    = err_q;
        cyc_d    = cyc_q;

        if (wr_n) begin
            if (busy) err_d = 1'b1;
            else      n_d[{wr_addr[4:0], 3'b000} +: 8] = wr_data;
        end
        if (wr_q) begin
            if (busy) err_d = 1'b1;
            else      q_d[{wr_addr[4:0], 3'b000} +: 8] = wr_data;
        end
        // clr is applied before go so that clr+go while busy still leaves err set.
        if (clr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (go && busy) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_LAUNCH;
                    snap_n_d = n_clamped;
                    snap_q_d = q_q[FE_W-1:0];
                end
            end
            S_LAUNCH: begin
                done_d  = 1'b0;
                cyc_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
                if (eng_done) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_d   = eng_result;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = 8'h00;
        if (rd_addr[7:5] == N_BASE[7:5]) begin
            rd_data_d = n_q[{rd_addr[4:0], 3'b000} +: 8];
        end else if (rd_addr[7:5] == Q_BASE[7:5]) begin
            rd_data_d = q_q[{rd_addr[4:0], 3'b000} +: 8];
        end else if (rd_addr[7:5] == RES_BASE[7:5]) begin
            rd_data_d = res_full[{rd_addr[4:0], 3'b000} +: 8];
        end else if (rd_addr == STATUS) begin
            rd_data_d = {5'b00000, err_q, done_q, busy};
        end else if (rd_addr[7:2] == CYC_BASE[7:2]) begin
            rd_data_d = cyc_ext[{rd_addr[1:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_q        <= '0;
            q_q        <= '0;
            res_q      <= '0;
            snap_n_q   <= '0;
            snap_q_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cyc_q      <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            n_q        <= n_d;
            q_q        <= q_d;
            res_q      <= res_d;
            snap_n_q   <= snap_n_d;
            snap_q_q   <= snap_q_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign irq       = done_q;
    assign eng_start = (state_q == S_LAUNCH);
    assign eng_n     = snap_n_q;
    assign eng_q     = snap_q_q;

endmodule

// File: tb/tb_curve25519_host_regs.sv
// Scoreboarded bench for the Curve25519 host register front end, with the engine
// played inline by each scenario; one unclamped and one clamped instance share the host bus.
module tb_curve25519_host_regs;

    localparam logic [7:0] A_N    = 8'h00;
    localparam logic [7:0] A_Q    = 8'h20;
    localparam logic [7:0] A_RES  = 8'h40;
    localparam logic [7:0] A_CTRL = 8'h60;
    localparam logic [7:0] A_STAT = 8'h61;
    localparam logic [7:0] A_CYC  = 8'h64;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_addr = 8'h00;
    logic [7:0]   wr_data = 8'h00;
    logic         rd_en = 1'b0;
    logic [7:0]   rd_addr = 8'h00;
    logic         eng_done = 1'b0;
    logic [254:0] eng_result = '0;

    logic [7:0]   rd_data0, rd_data1;
    logic         rd_valid0, rd_valid1, irq0, irq1, start0, start1;
    logic [254:0] n0, q0, n1, q1;

    int           n_run = 0;
    int           n_fail = 0;
    logic [7:0]   exp_q[$];
    string        nm_q[$];
    logic [7:0]   mon_e;
    string        mon_s;

    always #5 clock = ~clock;

    curve25519_host_regs #(.CLAMP(1'b0), .CNT_W(32)) dut0 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .irq(irq0),
        .eng_start(start0), .eng_n(n0), .eng_q(q0), .eng_done(eng_done), .eng_result(eng_result)
    );

    curve25519_host_regs #(.CLAMP(1'b1), .CNT_W(32)) dut1 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .irq(irq1),
        .eng_start(start1), .eng_n(n1), .eng_q(q1), .eng_done(eng_done), .eng_result(eng_result)
    );

    // Read scoreboard: both instances must return the byte queued when the read was issued.
    always @(negedge clock) begin
        if (rd_valid0 === 1'b1 || rd_valid1 === 1'b1) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_spurious: rd_valid=%b/%b with no read outstanding, required 0", rd_valid0, rd_valid1);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = nm_q.pop_front();
                if (rd_valid0 !== 1'b1 || rd_valid1 !== 1'b1 || rd_data0 !== mon_e || rd_data1 !== mon_e) begin
                    n_fail++;
                    $display("FAIL %s: got %02h/%02h valid %b/%b, required %02h", mon_s, rd_data0, rd_data1,
                             rd_valid0, rd_valid1, mon_e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        rd_en = 1'b1; rd_addr = a;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clock);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_run++;
        if (start0 !== 1'b0 || irq0 !== 1'b0 || rd_valid0 !== 1'b0 || rd_data0 !== 8'h00 || n0 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: start=%b irq=%b rd_valid=%b rd_data=%02h, required 0 0 0 00", start0, irq0, rd_valid0, rd_data0);
        end
        rd(A_STAT, 8'h00, "reset_status");
        n_run++;
        if (rd_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_valid_t1: got %b, required 1", rd_valid0);
        end
        idle(1);
        n_run++;
        if (rd_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_valid_single: got %b, required 0", rd_valid0);
        end
        rd(A_RES, 8'h00, "reset_result");
    endtask

    task automatic test_basic();
        logic [254:0] clamped9;
        clamped9 = 255'd8;
        clamped9[254] = 1'b1;
        wr(A_N, 8'h09);
        wr(A_Q, 8'h09);
        wr(A_CTRL, 8'h01);
        n_run++;
        if (start0 !== 1'b1 || n0 !== 255'd9 || q0 !== 255'd9) begin
            n_fail++;
            $display("FAIL launch_operands: start=%b n=%0h q=%0h, required 1 9 9", start0, n0, q0);
        end
        n_run++;
        if (start1 !== 1'b1 || n1 !== clamped9 || q1 !== 255'd9) begin
            n_fail++;
            $display("FAIL launch_clamped_9: n=%0h, required %0h", n1, clamped9);
        end
        idle(1);
        n_run++;
        if (start0 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_one_cycle: got %b, required 0", start0);
        end
        rd(A_RES, 8'h00, "result_while_busy");
        rd(A_STAT, 8'h01, "status_run");
        idle(37);
        eng_result = 255'h1234;
        eng_done = 1'b1;
        idle(1);
        rd(A_STAT, 8'h01, "status_capture");
        n_run++;
        if (irq0 !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_done: got %b, required 1", irq0);
        end
        rd(A_RES, 8'h34, "result_b0");
        rd(A_RES + 8'd1, 8'h12, "result_b1");
        rd(A_RES + 8'd2, 8'h00, "result_b2");
        rd(A_STAT, 8'h02, "status_done");
        rd(A_CYC, 8'd40, "cycles_b0");
        rd(A_CYC + 8'd1, 8'h00, "cycles_b1");
        rd(A_CTRL, 8'h00, "ctrl_reads_zero");
        rd(8'h62, 8'h00, "unmapped_zero");
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 32; i++) wr(8'(i), 8'hFF);
        wr(A_Q + 8'd31, 8'hFF);
        wr(A_CTRL, 8'h01);
        eng_done = 1'b0;
        n_run++;
        if (n1[2:0] !== 3'b000 || n1[254] !== 1'b1 || n1 !== ~255'h7) begin
            n_fail++;
            $display("FAIL clamp_n: got %0h, required %0h", n1, ~255'h7);
        end
        n_run++;
        if (n0 !== {255{1'b1}} || q0[254:248] !== 7'h7F) begin
            n_fail++;
            $display("FAIL noclamp_n: n=%0h q_top=%0h, required all ones, 7f", n0, q0[254:248]);
        end
        eng_result = {255{1'b1}};
        idle(3);
        eng_done = 1'b1;
        idle(3);
        rd(A_N, 8'hFF, "n_b0_unchanged");
        rd(A_N + 8'd31, 8'hFF, "n_b31_storage");
        rd(A_Q + 8'd31, 8'hFF, "q_b31_storage");
        rd(A_RES + 8'd31, 8'h7F, "result_b31_top");
        rd(A_RES, 8'hFF, "result_all_b0");
    endtask

    task automatic test_busy_writes();
        wr(A_CTRL, 8'h01);
        eng_done = 1'b0;
        idle(1);
        wr(A_N, 8'hAA);
        wr(A_CTRL, 8'h01);
        n_run++;
        if (start0 !== 1'b0 || n0 !== {255{1'b1}}) begin
            n_fail++;
            $display("FAIL busy_no_relaunch: start=%b n=%0h, required 0 and unchanged", start0, n0);
        end
        rd(A_N, 8'hFF, "busy_n_dropped");
        rd(A_STAT, 8'h05, "status_busy_err");
        eng_result = 255'hCAFE;
        eng_done = 1'b1;
        idle(2);
        rd(A_STAT, 8'h06, "status_done_err");
        rd(A_RES, 8'hFE, "result_cafe");
        wr(A_CTRL, 8'h02);
        rd(A_STAT, 8'h00, "status_clr");
        n_run++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clr: got %b, required 0", irq0);
        end
        wr(A_RES, 8'h55);
        wr(A_STAT, 8'hFF);
        rd(A_RES, 8'hFE, "ro_write_ignored");
        rd(A_STAT, 8'h00, "ro_write_no_err");
        wr(A_N, 8'hAA);
        wr(A_CTRL, 8'h01);
        eng_done = 1'b0;
        wr(A_N, 8'h00);
        eng_result = 255'h42;
        eng_done = 1'b1;
        idle(3);
        rd(A_STAT, 8'h06, "err_before_clrgo");
        wr(A_CTRL, 8'h03);
        eng_done = 1'b0;
        rd(A_STAT, 8'h01, "clrgo_launch");
        eng_done = 1'b1;
        idle(3);
        rd(A_STAT, 8'h02, "clrgo_done");
        rd(A_RES, 8'h42, "clrgo_result");
    endtask

    task automatic test_stale_done();
        int pulses;
        eng_done = 1'b1;
        eng_result = 255'h77;
        pulse_reset();
        idle(4);
        rd(A_RES, 8'h00, "stale_not_captured");
        rd(A_STAT, 8'h00, "stale_idle_status");
        wr(A_CTRL, 8'h01);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (start0 === 1'b1) pulses++;
            idle(1);
        end
        n_run++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL stale_one_launch: got %0d pulses, required 1", pulses);
        end
        rd(A_RES, 8'h77, "stale_result_after_start");
        rd(A_CYC, 8'h01, "stale_cycles");
        rd(A_STAT, 8'h02, "stale_status");
    endtask

    task automatic test_reset_mid();
        wr(A_CTRL, 8'h02);
        wr(A_CTRL, 8'h01);
        eng_done = 1'b0;
        eng_result = 255'hBEEF;
        idle(5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        eng_done = 1'b1;
        idle(3);
        rd(A_STAT, 8'h00, "midreset_status");
        rd(A_RES, 8'h00, "midreset_no_capture");
        rd(A_CYC, 8'h00, "midreset_cycles");
        n_run++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_irq: got %b, required 0", irq0);
        end
        wr(A_CTRL, 8'h01);
        n_run++;
        if (start0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_relaunch: got %b, required 1", start0);
        end
        eng_done = 1'b0;
        idle(4);
        eng_done = 1'b1;
        idle(3);
        rd(A_RES, 8'hEF, "relaunch_b0");
        rd(A_RES + 8'd1, 8'hBE, "relaunch_b1");
        rd(A_STAT, 8'h02, "relaunch_status");
    endtask

    task automatic test_back_to_back();
        wr(A_N + 8'd5, 8'h11);
        wr_en = 1'b1; wr_addr = A_N + 8'd5; wr_data = 8'h22;
        rd_en = 1'b1; rd_addr = A_N + 8'd5;
        exp_q.push_back(8'h11);
        nm_q.push_back("rw_same_old");
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rd(A_N + 8'd5, 8'h22, "rw_same_new");
        rd(A_N + 8'd4, 8'h00, "rw_neighbour");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_busy_writes();
        test_stale_done();
        test_reset_mid();
        test_back_to_back();
        idle(3);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reads_outstanding: %0d reads never returned, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/curve25519_host_regs.md
Name: curve25519_host_regs

Overview:
- Byte-addressed register front end that acts as the initiator for the Curve25519 scalar-multiply engine.
- The I2C slave byte interface writes the scalar and the point one byte at a time. The block then pulses `start`, waits for `done`, captures `result`, and exposes it for byte-wise readback.
- Adds optional RFC 7748 scalar clamping, sticky status flags and a cycle counter.
- Sits between the I2C slave and the engine, which is instantiated outside this block.

Parameters:
- CLAMP, 1: when 1, clamp the scalar at launch (clear bits 0..2, set bit 254).
- CNT_W, 32: width of the operation cycle counter (max 32).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  host byte-write strobe
- wr_addr  in  8  host write address
- wr_data  in  8  host write data
- rd_en  in  1  host byte-read strobe
- rd_addr  in  8  host read address
- rd_data  out  8  read data, registered
- rd_valid  out  1  high one cycle after rd_en
- irq  out  1  high while STATUS.done=1
- eng_start  out  1  one-cycle start pulse to engine
- eng_n  out  255  scalar to engine
- eng_q  out  255  point u-coordinate to engine
- eng_done  in  1  engine completion, level
- eng_result  in  255  engine result

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Map, all multi-byte fields little-endian:
  - 0x00-0x1F N (R/W)
  - 0x20-0x3F Q (R/W)
  - 0x40-0x5F RESULT (RO)
  - 0x60 CTRL (WO): bit0 go, bit1 clr
  - 0x61 STATUS (RO): bit0 busy, bit1 done, bit2 err
  - 0x64-0x67 CYCLES (RO)
  - any other address reads 0x00.
- Byte 31 bit 7 of N, Q and RESULT is storage only:
  - not driven to the engine;
  - RESULT byte 31 bit 7 reads 0.
- Reset values: all storage 0; rd_data=0, rd_valid=0, eng_start=0, irq=0; state IDLE.
- FSM states: IDLE, LAUNCH, RUN, CAPTURE.
  - IDLE: write to CTRL with go=1 -> LAUNCH.
  - LAUNCH (1 cycle):
    - eng_start=1;
    - eng_n/eng_q are taken from the N and Q registers, clamped when CLAMP=1. They are held stable by a snapshot register until the next launch;
    - clear done; clear CYCLES;
    - -> RUN.
  - RUN:
    - CYCLES increments each cycle and saturates at all-ones;
    - eng_done=1 -> CAPTURE.
    - The engine forces `done` low during the start cycle, so no masking cycle is needed. eng_done is not sampled in LAUNCH.
  - CAPTURE (1 cycle): RESULT <= eng_result; done<=1; -> IDLE.
- busy=1 in LAUNCH, RUN and CAPTURE.
- Writes while busy:
  - writes to N or Q: data dropped, err<=1;
  - go while busy: ignored, err<=1.
- clr=1 clears done and err. If the same write also sets go, clr applies first, then launch; err and done end at 0.
- Writes to RO addresses are ignored, with no err.
- Reads:
  - rd_en in cycle T gives rd_data/rd_valid in T+1;
  - a read of RESULT during busy returns the previous result;
  - a read of STATUS in the CAPTURE cycle returns busy=1, done=0.
- Simultaneous read and write to the same byte: the read returns the old value.
- Reset mid-operation:
  - the block returns to IDLE with all registers cleared;
  - the engine has no reset and may keep running. Its later eng_done is ignored because state is IDLE;
  - the next go re-pulses eng_start, which restarts the engine cleanly.
- eng_done high in IDLE (stale from a previous operation): ignored.

Decomposition:
- Shared package holds:
  - address constants (N_BASE=0x00, Q_BASE=0x20, RES_BASE=0x40, CTRL=0x60, STATUS=0x61, CYC_BASE=0x64);
  - STATUS/CTRL bit indices;
  - FSM state enum;
  - FE_W=255.
- One sub-module: curve25519_clamp (combinational, 255-bit in/out, CLAMP enable).

Test Plan:
- Reset, then read 0x61 and 0x40 -> 0x00, 0x00; rd_valid exactly one cycle after rd_en.
- Write N=9 (byte0=0x09, rest 0) and Q=9, CLAMP=0, write 0x60=0x01:
  - eng_start is high for exactly 1 cycle, with eng_n=9 and eng_q=9;
  - engine model asserts done after 40 cycles with result 0x1234 -> RESULT bytes 0x34,0x12 and STATUS=0x02;
  - irq=1; CYCLES reads 40±1.
- CLAMP=1, N all 0xFF -> eng_n has bits 0..2 = 0 and bit 254 = 1; N register readback unchanged (0xFF).
- While busy, write N byte0=0xAA and go -> N readback unchanged, STATUS=0x05; after completion STATUS=0x06; write clr -> 0x00.
- Model holds eng_done=1 permanently, then reset, then go -> exactly one LAUNCH pulse; the stale done is not captured before eng_start.
- Assert reset during RUN, then a model done arrives -> no RESULT update and STATUS=0x00; the next go completes normally.
